// File: rtl/merge_reader_if.sv
// -----------------------------------------------------------------------------
// merge_reader_if
// Ping-pong line-register link between the merge writer and the VGA reader.
//   R/G/B_inRegA/B  : packed bank contents, pixel k at bits [k*DW +: DW]
//   bank_full       : the bank currently being written holds PIXELS pixels
//   readVgaSelector : 0 = reader owns A / merge writes B, 1 = the reverse
//   swap_ack        : one-clk pulse when ownership flips; merge clears its count
// master = merge side, slave = reader side.
// -----------------------------------------------------------------------------
interface merge_reader_if #(
  parameter int PIXELS = 16,
  parameter int DW     = 8
);
  localparam int BW = PIXELS * DW;

  logic [BW-1:0] R_inRegA;
  logic [BW-1:0] G_inRegA;
  logic [BW-1:0] B_inRegA;
  logic [BW-1:0] R_inRegB;
  logic [BW-1:0] G_inRegB;
  logic [BW-1:0] B_inRegB;
  logic          bank_full;
  logic          readVgaSelector;
  logic          swap_ack;

  modport master (
    output R_inRegA, G_inRegA, B_inRegA,
    output R_inRegB, G_inRegB, B_inRegB,
    output bank_full,
    input  readVgaSelector, swap_ack
  );

  modport slave (
    input  R_inRegA, G_inRegA, B_inRegA,
    input  R_inRegB, G_inRegB, B_inRegB,
    input  bank_full,
    output readVgaSelector, swap_ack
  );
endinterface

// File: rtl/merge_reader.sv
// -----------------------------------------------------------------------------
// merge_reader
// Read-side consumer of the merge ping-pong line registers. Captures the bank
// merge has just filled into shift registers, hands the other bank back to
// merge, and emits one RGB pixel (pixel 0 first) per VGA pixel tick.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   pix_en          : one-clk pixel tick (never on consecutive clocks)
//   video_on        : active display area
//   bus (slave)     : bank data, bank_full, readVgaSelector, swap_ack
//   R/G/B_out       : registered pixel, valid 1 clk after its tick
//   pixel_valid     : R/G/B_out carry a real bank pixel
//   underrun        : one-clk pulse when a visible pixel had no data
//   underrun_cnt    : saturating underrun count
// -----------------------------------------------------------------------------
module merge_reader #(
  parameter int PIXELS = 16,
  parameter int DW     = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_en,
  input  logic           video_on,
  merge_reader_if.slave  bus,
  output logic [DW-1:0]  R_out,
  output logic [DW-1:0]  G_out,
  output logic [DW-1:0]  B_out,
  output logic           pixel_valid,
  output logic           underrun,
  output logic [7:0]     underrun_cnt
);
  localparam int BW = PIXELS * DW;
  localparam int IW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PIXELS - 1);

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t        state;
  logic [BW-1:0] r_sr_p0;
  logic [BW-1:0] g_sr_p0;
  logic [BW-1:0] b_sr_p0;
  logic [IW-1:0] idx;
  logic          sel;
  logic          swap;

  assign bus.readVgaSelector = sel;
  assign bus.swap_ack        = swap;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // ---- stage p0: bank shift registers -> stage p1: registered pixel outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= WAIT;
      sel          <= 1'b1;
      swap         <= 1'b0;
      idx          <= '0;
      r_sr_p0      <= '0;
      g_sr_p0      <= '0;
      b_sr_p0      <= '0;
      R_out        <= '0;
      G_out        <= '0;
      B_out        <= '0;
      pixel_valid  <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      swap     <= 1'b0;
      underrun <= 1'b0;
      case (state)
        WAIT, LOAD: begin
          // No pixel data owned yet: any tick shows black, and a visible
          // one counts as an underrun.
          if (pix_en) begin
            R_out       <= '0;
            G_out       <= '0;
            B_out       <= '0;
            pixel_valid <= 1'b0;
            if (video_on) begin
              underrun     <= 1'b1;
              underrun_cnt <= sat_inc(underrun_cnt);
            end
          end
          if (state == LOAD) begin
            // The write bank is the one the reader does not currently own.
            if (sel) begin
              r_sr_p0 <= bus.R_inRegA;
              g_sr_p0 <= bus.G_inRegA;
              b_sr_p0 <= bus.B_inRegA;
            end else begin
              r_sr_p0 <= bus.R_inRegB;
              g_sr_p0 <= bus.G_inRegB;
              b_sr_p0 <= bus.B_inRegB;
            end
            sel   <= ~sel;
            swap  <= 1'b1;
            idx   <= '0;
            state <= SHIFT;
          end else if (bus.bank_full) begin
            state <= LOAD;
          end
        end

        SHIFT: begin
          if (pix_en) begin
            if (video_on) begin
              R_out       <= r_sr_p0[DW-1:0];
              G_out       <= g_sr_p0[DW-1:0];
              B_out       <= b_sr_p0[DW-1:0];
              pixel_valid <= 1'b1;
              r_sr_p0     <= r_sr_p0 >> DW;
              g_sr_p0     <= g_sr_p0 >> DW;
              b_sr_p0     <= b_sr_p0 >> DW;
              if (idx == LAST_IDX) begin
                idx   <= '0;
                state <= bus.bank_full ? LOAD : WAIT;
              end else begin
                idx <= idx + IW'(1);
              end
            end else begin
              // Blanking tick: black, position in the line is held.
              R_out       <= '0;
              G_out       <= '0;
              B_out       <= '0;
              pixel_valid <= 1'b0;
            end
          end
        end

        default: state <= WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_merge_reader.sv
module tb_merge_reader;
  localparam int PIXELS = 16;
  localparam int DW     = 8;
  localparam int BW     = PIXELS * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pix_en = 1'b0;
  logic          video_on = 1'b0;
  logic [DW-1:0] R_out, G_out, B_out;
  logic          pixel_valid, underrun;
  logic [7:0]    underrun_cnt;

  merge_reader_if #(.PIXELS(PIXELS), .DW(DW)) bus ();

  merge_reader #(.PIXELS(PIXELS), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .video_on    (video_on),
    .bus         (bus.slave),
    .R_out       (R_out),
    .G_out       (G_out),
    .B_out       (B_out),
    .pixel_valid (pixel_valid),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model: queue of pixels still owned ----------
  logic [23:0] pq[$];
  bit          m_loading;
  logic        m_sel;
  logic [7:0]  m_r, m_g, m_b, m_cnt;
  logic        m_valid, m_under, m_swap;

  task automatic model_reset();
    pq.delete();
    m_loading = 0;
    m_sel = 1'b1;
    m_r = 0; m_g = 0; m_b = 0; m_cnt = 0;
    m_valid = 0; m_under = 0; m_swap = 0;
  endtask

  task automatic model_step();
    logic [23:0] p;
    m_under = 0;
    m_swap  = 0;
    if (pq.size() > 0) begin
      if (pix_en) begin
        if (video_on) begin
          p = pq.pop_front();
          {m_r, m_g, m_b} = p;
          m_valid = 1;
          if (pq.size() == 0 && bus.bank_full) m_loading = 1;
        end else begin
          m_r = 0; m_g = 0; m_b = 0; m_valid = 0;
        end
      end
    end else begin
      if (pix_en) begin
        m_r = 0; m_g = 0; m_b = 0; m_valid = 0;
        if (video_on) begin
          m_under = 1;
          if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end
      end
      if (m_loading) begin
        for (int k = 0; k < PIXELS; k++) begin
          if (m_sel)
            pq.push_back({bus.R_inRegA[k*DW +: DW], bus.G_inRegA[k*DW +: DW], bus.B_inRegA[k*DW +: DW]});
          else
            pq.push_back({bus.R_inRegB[k*DW +: DW], bus.G_inRegB[k*DW +: DW], bus.B_inRegB[k*DW +: DW]});
        end
        m_sel = ~m_sel;
        m_swap = 1;
        m_loading = 0;
      end else if (bus.bank_full) begin
        m_loading = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("R_out", 32'(R_out), 32'(m_r));
    chk("G_out", 32'(G_out), 32'(m_g));
    chk("B_out", 32'(B_out), 32'(m_b));
    chk("pixel_valid", 32'(pixel_valid), 32'(m_valid));
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
    chk("readVgaSelector", 32'(bus.readVgaSelector), 32'(m_sel));
    chk("swap_ack", 32'(bus.swap_ack), 32'(m_swap));
  endtask

  // one clock: model follows the edge, DUT sampled 1 ns later
  task automatic cyc();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
    check_model();
  endtask

  task automatic tick();
    pix_en = 1'b1; cyc();
    pix_en = 1'b0; cyc();
  endtask

  // mode 0: constant bytes, 1: test-plan pattern, 2: index pattern
  task automatic fill_bank(input bit to_b, input int mode, input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
    logic [BW-1:0] r, g, b;
    logic [7:0] pr[4], pg[4], pb[4];
    pr = '{8'h17, 8'h30, 8'h87, 8'h30};
    pg = '{8'h17, 8'h54, 8'h32, 8'h54};
    pb = '{8'h17, 8'h41, 8'h50, 8'h41};
    for (int k = 0; k < PIXELS; k++) begin
      case (mode)
        1: begin r[k*DW +: DW] = pr[k%4]; g[k*DW +: DW] = pg[k%4]; b[k*DW +: DW] = pb[k%4]; end
        2: begin r[k*DW +: DW] = 8'(k); g[k*DW +: DW] = 8'(8'h40 + k); b[k*DW +: DW] = 8'(8'h80 + k); end
        default: begin r[k*DW +: DW] = cr; g[k*DW +: DW] = cg; b[k*DW +: DW] = cb; end
      endcase
    end
    if (to_b) begin bus.R_inRegB = r; bus.G_inRegB = g; bus.B_inRegB = b; end
    else      begin bus.R_inRegA = r; bus.G_inRegA = g; bus.B_inRegA = b; end
  endtask

  task automatic rand_banks();
    bus.R_inRegA = {$urandom, $urandom, $urandom, $urandom};
    bus.G_inRegA = {$urandom, $urandom, $urandom, $urandom};
    bus.B_inRegA = {$urandom, $urandom, $urandom, $urandom};
    bus.R_inRegB = {$urandom, $urandom, $urandom, $urandom};
    bus.G_inRegB = {$urandom, $urandom, $urandom, $urandom};
    bus.B_inRegB = {$urandom, $urandom, $urandom, $urandom};
  endtask

  typedef struct {
    logic       pe, vo, bf;
    logic       ev;
    logic [7:0] er, eg, eb;
    logic       esel, eswap;
  } vec_t;

  vec_t vt[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // first bank from reset: WAIT->LOAD, LOAD (swap), then pixels 0..3 of bank A
    vt[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h17, 8'h17, 8'h17, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h17, 8'h17, 8'h17, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h30, 8'h54, 8'h41, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 8'h54, 8'h41, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h87, 8'h32, 8'h50, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h87, 8'h32, 8'h50, 1'b0, 1'b0};
    vt[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h30, 8'h54, 8'h41, 1'b0, 1'b0};
    vt[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 8'h54, 8'h41, 1'b0, 1'b0};

    bus.bank_full = 1'b0;
    fill_bank(1'b0, 0, 8'h00, 8'h00, 8'h00);
    fill_bank(1'b1, 0, 8'h00, 8'h00, 8'h00);
    model_reset();

    // reset held while ticks arrive: nothing counts
    reset = 1'b0; video_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pix_en = (i % 2 == 0);
      cyc();
    end
    pix_en = 1'b0;
    chk("rst sel", 32'(bus.readVgaSelector), 32'd1);
    chk("rst cnt", 32'(underrun_cnt), 32'd0);
    chk("rst valid", 32'(pixel_valid), 32'd0);
    chk("rst rgb", 32'({R_out, G_out, B_out}), 32'd0);

    // bank A test pattern, table-driven first pixels
    reset = 1'b1;
    fill_bank(1'b0, 1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      pix_en = vt[i].pe; video_on = vt[i].vo; bus.bank_full = vt[i].bf;
      cyc();
      chk($sformatf("vec%0d valid", i), 32'(pixel_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d rgb", i), 32'({R_out, G_out, B_out}), 32'({vt[i].er, vt[i].eg, vt[i].eb}));
      chk($sformatf("vec%0d sel", i), 32'(bus.readVgaSelector), 32'(vt[i].esel));
      chk($sformatf("vec%0d swap", i), 32'(bus.swap_ack), 32'(vt[i].eswap));
    end

    // remaining bank A pixels; bank B filled before pixel 15
    for (int k = 4; k < 15; k++) begin
      if (k == 14) begin
        fill_bank(1'b1, 0, 8'h20, 8'h50, 8'h40);
        bus.bank_full = 1'b1;
      end
      tick();
    end
    pix_en = 1'b1; cyc();
    chk("pix15 R", 32'(R_out), 32'h30);
    pix_en = 1'b0; cyc();
    chk("swapB sel", 32'(bus.readVgaSelector), 32'd1);
    chk("swapB ack", 32'(bus.swap_ack), 32'd1);
    bus.bank_full = 1'b0;
    pix_en = 1'b1; cyc();
    chk("B pix0", 32'({R_out, G_out, B_out}), 32'h205040);
    chk("B pix0 valid", 32'(pixel_valid), 32'd1);
    chk("B no underrun", 32'(underrun_cnt), 32'd0);
    pix_en = 1'b0; cyc();

    // drain bank B with nothing queued, then three starved ticks
    for (int k = 1; k < PIXELS; k++) tick();
    for (int k = 0; k < 3; k++) begin
      pix_en = 1'b1; cyc();
      chk("starve underrun", 32'(underrun), 32'd1);
      chk("starve valid", 32'(pixel_valid), 32'd0);
      chk("starve rgb", 32'({R_out, G_out, B_out}), 32'd0);
      pix_en = 1'b0; cyc();
    end
    chk("underrun_cnt 3", 32'(underrun_cnt), 32'd3);

    // recovery into bank A with an index pattern
    fill_bank(1'b0, 2, 8'h00, 8'h00, 8'h00);
    bus.bank_full = 1'b1;
    cyc(); cyc();
    bus.bank_full = 1'b0;
    chk("resume sel", 32'(bus.readVgaSelector), 32'd0);
    for (int k = 0; k < 7; k++) tick();
    chk("pix6", 32'(R_out), 32'd6);

    // blanking at pixel 7 holds the position
    video_on = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("blank valid", 32'(pixel_valid), 32'd0);
      chk("blank rgb", 32'({R_out, G_out, B_out}), 32'd0);
    end
    video_on = 1'b1;
    pix_en = 1'b1; cyc();
    chk("pix7 after blank", 32'({R_out, G_out, B_out}), 32'h074787);
    pix_en = 1'b0; cyc();
    for (int k = 8; k < PIXELS; k++) tick();
    chk("pix15 idx", 32'(R_out), 32'd15);

    // saturation of the underrun counter
    for (int k = 0; k < 300; k++) tick();
    chk("cnt saturate", 32'(underrun_cnt), 32'd255);
    pix_en = 1'b1; cyc();
    chk("sat pulse", 32'(underrun), 32'd1);
    chk("sat hold", 32'(underrun_cnt), 32'd255);
    pix_en = 1'b0; cyc();

    // randomized traffic
    reset = 1'b0; cyc(); reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      pix_en = (!pix_en) && ($urandom_range(0, 2) != 0);
      video_on = ($urandom_range(0, 9) < 8);
      bus.bank_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) rand_banks();
      cyc();
    end
    pix_en = 1'b0; video_on = 1'b1; bus.bank_full = 1'b0;

    // asynchronous reset mid-SHIFT
    reset = 1'b0; cyc(); reset = 1'b1;
    fill_bank(1'b0, 2, 8'h00, 8'h00, 8'h00);
    bus.bank_full = 1'b1; cyc(); cyc(); bus.bank_full = 1'b0;
    pix_en = 1'b0; cyc();
    tick(); tick(); tick();
    chk("pre-reset valid", 32'(pixel_valid), 32'd1);
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk("async rst valid", 32'(pixel_valid), 32'd0);
    chk("async rst rgb", 32'({R_out, G_out, B_out}), 32'd0);
    chk("async rst sel", 32'(bus.readVgaSelector), 32'd1);
    cyc();
    reset = 1'b1;

    // asynchronous reset mid-LOAD: no swap_ack afterwards
    bus.bank_full = 1'b1; cyc();
    bus.bank_full = 1'b0;
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk("load rst swap", 32'(bus.swap_ack), 32'd0);
    chk("load rst sel", 32'(bus.readVgaSelector), 32'd1);
    cyc();
    reset = 1'b1;
    cyc(); cyc();
    chk("no late swap", 32'(bus.swap_ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
